// File: rtl/fact_pkg.sv
// Shared types and defaults for the iterative factorial engine.
package fact_pkg;

  localparam int unsigned ST_W     = 3;
  localparam int unsigned N_W_DEF  = 4;
  localparam int unsigned P_W_DEF  = 32;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_MULT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/fact_engine_if.sv
// Request/result bundle between the board I/O layer and the factorial engine.
interface fact_engine_if
  import fact_pkg::*;
#(
  parameter int unsigned N_W = N_W_DEF,
  parameter int unsigned P_W = P_W_DEF
);

  logic            go;
  logic [N_W-1:0]  n_in;
  logic            busy;
  logic            done;
  logic [P_W-1:0]  result;
  logic            ovf;
  logic [ST_W-1:0] debug_cs;

  modport master (
    output go, n_in,
    input  busy, done, result, ovf, debug_cs
  );

  modport slave (
    input  go, n_in,
    output busy, done, result, ovf, debug_cs
  );

endinterface

// File: rtl/fact_ctrl_fsm.sv
// Controller for the factorial engine: sequences LOAD/CHECK/MULT/DONE and decodes
// datapath strobes and status from the registered state only.
module fact_ctrl_fsm
  import fact_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            cnt_gt1,
  output logic            ld,
  output logic            cnt_en,
  output logic            busy,
  output logic            done,
  output logic [ST_W-1:0] debug_cs
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = ST_IDLE;
    ld       = 1'b0;
    cnt_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    debug_cs = state_q;
    case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        state_d = go ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        ld      = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = cnt_gt1 ? ST_MULT : ST_DONE;
      end
      ST_MULT: begin
        cnt_en  = 1'b1;
        state_d = ST_CHECK;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      // Unused codes fall back to IDLE on the next edge.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/fact_engine.sv
// Iterative factorial engine: counter, product register and multiplier around fact_ctrl_fsm.
// Optional overflow detection is enabled by defining FACT_OVF_DETECT_EN.
module fact_engine
  import fact_pkg::*;
#(
  parameter int unsigned N_W = N_W_DEF,
  parameter int unsigned P_W = P_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fact_engine_if.slave  bus
);

  logic           ld;
  logic           cnt_en;
  logic           cnt_gt1;
  logic [N_W-1:0] cnt_q;
  logic [P_W-1:0] prod_q;
  logic [P_W-1:0] prod_next;

  assign cnt_gt1 = (cnt_q > N_W'(1));

  fact_ctrl_fsm u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .go       (bus.go),
    .cnt_gt1  (cnt_gt1),
    .ld       (ld),
    .cnt_en   (cnt_en),
    .busy     (bus.busy),
    .done     (bus.done),
    .debug_cs (bus.debug_cs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      prod_q <= '0;
    end else if (ld) begin
      cnt_q  <= bus.n_in;
      prod_q <= P_W'(1);
    end else if (cnt_en) begin
      cnt_q  <= cnt_q - N_W'(1);
      prod_q <= prod_next;
    end
  end

`ifdef FACT_OVF_DETECT_EN
  logic [P_W+N_W-1:0] prod_full;
  logic               ovf_q;

  assign prod_full = (P_W+N_W)'(prod_q) * (P_W+N_W)'(cnt_q);
  assign prod_next = prod_full[P_W-1:0];

  // Sticky for the whole run so it stays valid alongside done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ld) begin
      ovf_q <= 1'b0;
    end else if (cnt_en && (|prod_full[P_W+N_W-1:P_W])) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign prod_next = prod_q * P_W'(cnt_q);
  assign bus.ovf   = 1'b0;
`endif

  assign bus.result = prod_q;

endmodule

// File: tb/tb_fact_engine.sv
// Self-checking bench for fact_engine: constant vector table, hand-written corner
// sequences, and randomized runs against an arithmetic factorial model.
module tb_fact_engine;
  import fact_pkg::*;

`ifdef FACT_OVF_DETECT_EN
  localparam bit OvfOn = 1'b1;
`else
  localparam bit OvfOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fact_engine_if #(.N_W(4), .P_W(32)) bus ();

  fact_engine #(.N_W(4), .P_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n;
    logic [31:0] res;
    logic        ovf_if_en;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // n! evaluated step by step as an unbounded product; overflow means some partial
  // product needed more than 32 bits.
  task automatic model(input int n, output logic [31:0] r, output logic o);
    longint unsigned p;
    p = 1;
    o = 1'b0;
    for (int k = 2; k <= n; k++) begin
      p = p * longint'(k);
      if (p >= 64'h1_0000_0000) o = 1'b1;
      p = p % 64'h1_0000_0000;
    end
    r = p[31:0];
  endtask

  function automatic int exp_cycles(input int n);
    return 3 + 2 * ((n > 1) ? (n - 1) : 0);
  endfunction

  // Starts a run from IDLE with a one-cycle go pulse, waits for done and checks it.
  task automatic run(input int n, input logic [31:0] exp_res, input logic exp_ovf,
                     input string name);
    int c;
    int busy_bad;
    busy_bad = 0;
    bus.n_in = 4'(n);
    bus.go   = 1'b1;
    for (c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.go = 1'b0;
      if (bus.done) break;
      if (!bus.busy) busy_bad++;
    end
    chk({name, " latency"}, c, exp_cycles(n));
    chk({name, " result"}, bus.result, exp_res);
    chk({name, " ovf"}, bus.ovf, exp_ovf);
    chk({name, " busy_gaps"}, busy_bad, 0);
    chk({name, " busy_at_done"}, bus.busy, 1);
    @(posedge clk); #1;
    chk({name, " done_after"}, bus.done, 0);
    chk({name, " busy_after"}, bus.busy, 0);
    chk({name, " result_hold"}, bus.result, exp_res);
  endtask

  initial begin
    int          c;
    int          pulses;
    int          first;
    logic [31:0] r;
    logic        o;

    vecs[0] = '{n: 0,  res: 32'd1,          ovf_if_en: 1'b0};
    vecs[1] = '{n: 1,  res: 32'd1,          ovf_if_en: 1'b0};
    vecs[2] = '{n: 2,  res: 32'd2,          ovf_if_en: 1'b0};
    vecs[3] = '{n: 5,  res: 32'd120,        ovf_if_en: 1'b0};
    vecs[4] = '{n: 12, res: 32'd479001600,  ovf_if_en: 1'b0};
    vecs[5] = '{n: 13, res: 32'd1932053504, ovf_if_en: 1'b1};
    vecs[6] = '{n: 14, res: 32'd1278945280, ovf_if_en: 1'b1};
    vecs[7] = '{n: 15, res: 32'd2004310016, ovf_if_en: 1'b1};

    bus.go   = 1'b0;
    bus.n_in = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst result", bus.result, 0);
    chk("rst ovf", bus.ovf, 0);
    chk("rst state", bus.debug_cs, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle state", bus.debug_cs, 0);

    foreach (vecs[i]) begin
      run(vecs[i].n, vecs[i].res, vecs[i].ovf_if_en & OvfOn, $sformatf("vec n=%0d", vecs[i].n));
    end

    // Operand changes after LOAD must not affect the run
    bus.n_in = 4'd12;
    bus.go   = 1'b1;
    for (c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.go = 1'b0;
      if (c == 2) bus.n_in = 4'd3;
      if (bus.done) break;
    end
    chk("nin_change latency", c, exp_cycles(12));
    chk("nin_change result", bus.result, 479001600);
    @(posedge clk); #1;

    // go re-pulsed during MULT is ignored; state walk checked on the way
    pulses = 0;
    first  = 0;
    bus.n_in = 4'd6;
    bus.go   = 1'b1;
    for (c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin bus.go = 1'b0; chk("walk load", bus.debug_cs, 1); end
      if (c == 2) chk("walk check", bus.debug_cs, 2);
      if (c == 3) begin bus.go = 1'b1; chk("walk mult", bus.debug_cs, 3); end
      if (c == 4) bus.go = 1'b0;
      if (bus.done) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("repulse done_count", pulses, 1);
    chk("repulse latency", first, exp_cycles(6));
    chk("repulse result", bus.result, 720);

    // go held high: back-to-back runs with one IDLE cycle in between
    bus.n_in = 4'd6;
    bus.go   = 1'b1;
    for (c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (bus.done) break;
    end
    chk("held first latency", c, exp_cycles(6));
    chk("held first result", bus.result, 720);
    for (c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (bus.done) break;
    end
    bus.go = 1'b0;
    chk("held done_to_done", c, exp_cycles(6) + 1);
    chk("held second result", bus.result, 720);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("held back_idle", bus.busy, 0);

    // Asynchronous reset in the middle of MULT
    bus.n_in = 4'd7;
    bus.go   = 1'b1;
    for (c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.go = 1'b0;
    end
    chk("pre_rst state", bus.debug_cs, 3);
    rst = 1'b1;
    #1;
    chk("async_rst state", bus.debug_cs, 0);
    chk("async_rst result", bus.result, 0);
    chk("async_rst busy", bus.busy, 0);
    chk("async_rst ovf", bus.ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("async_rst no_done", pulses, 0);
    run(3, 32'd6, 1'b0, "after_rst n=3");

    // Randomized runs against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      int n;
      n = int'($urandom_range(0, 15));
      model(n, r, o);
      run(n, r, o & OvfOn, $sformatf("rand%0d n=%0d", i, n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
